// File: rtl/cpld_r_maker_pkg.sv
// cpld_r_maker_pkg: completion header layout, constants and decode helper
package cpld_r_maker_pkg;

    localparam logic [2:0] FMT_CPL     = 3'b000;
    localparam logic [2:0] FMT_CPLD    = 3'b010;
    localparam logic [4:0] TYPE_CPL    = 5'b01010;
    localparam logic [2:0] CPL_SC      = 3'b000;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] rsvd;
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic [7:0]  lower_addr;
        logic [15:0] completer_id;
        logic [2:0]  status;
        logic        bcm;
        logic [11:0] byte_count;
        logic [2:0]  fmt;
        logic [4:0]  typ;
        logic [13:0] attr;
        logic [9:0]  length;
    } cpl_hdr_t;

    typedef enum logic [1:0] {IDLE, DATA, ERR} state_t;

    typedef enum logic [1:0] {HDR_BAD, HDR_DATA, HDR_ERR} hdr_kind_t;

    typedef struct packed {
        hdr_kind_t  kind;
        logic [7:0] beats;
        logic [7:0] drop;
        logic       is_final;
    } hdr_info_t;

    // beats: payload beats for a good CplD, synthesized SLVERR beats otherwise;
    // drop: payload beats of an unsuccessful CplD that must still be drained
    function automatic hdr_info_t decode_cpl_hdr(input cpl_hdr_t h);
        hdr_info_t   info;
        logic [10:0] len_dw;
        logic [12:0] len_bytes;
        logic [12:0] bytes;
        logic [7:0]  len_beats;
        logic        is_cpld;
        logic        is_cpl;
        len_dw    = (h.length == '0) ? 11'd1024 : {1'b0, h.length};
        len_bytes = {len_dw, 2'b00};
        bytes     = (h.byte_count == '0) ? 13'd4096 : {1'b0, h.byte_count};
        len_beats = 8'((len_dw + 11'd7) >> 3);
        is_cpld   = (h.fmt == FMT_CPLD) && (h.typ == TYPE_CPL);
        is_cpl    = (h.fmt == FMT_CPL) && (h.typ == TYPE_CPL);
        info.kind = (is_cpld && h.status == CPL_SC) ? HDR_DATA :
                    (is_cpld || is_cpl) ? HDR_ERR : HDR_BAD;
        info.beats = (info.kind == HDR_DATA) ? len_beats :
                     (h.byte_count == '0) ? 8'd1 : 8'(({1'b0, h.byte_count} + 13'd31) >> 5);
        info.drop = (is_cpld && info.kind == HDR_ERR) ? len_beats : 8'd0;
        info.is_final = bytes <= len_bytes;
        return info;
    endfunction

endpackage

// File: rtl/axi4_r_if.sv
// AXI4_R_IF: AXI4 read-data channel bundle
interface AXI4_R_IF #(
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 8
);
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [ID_WIDTH-1:0]   rid;

    modport master(output rvalid, rdata, rresp, rlast, rid, input rready);
    modport slave(input rvalid, rdata, rresp, rlast, rid, output rready);
endinterface

// File: rtl/cpld_r_maker.sv
// cpld_r_maker: turns RX completion headers and payload into AXI4 R beats
module cpld_r_maker
    import cpld_r_maker_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hdr_empty,
    input  logic [127:0]          hdr_rdata,
    output logic                  hdr_rden,
    input  logic                  pld_empty,
    input  logic [DATA_WIDTH-1:0] pld_rdata,
    output logic                  pld_rden,
    AXI4_R_IF.master              r_if,
    output logic                  err_malformed
);

    state_t                state;
    state_t                state_nx;
    cpl_hdr_t              hdr;
    hdr_info_t             info;
    logic [7:0]            beats_left;
    logic [7:0]            beats_nx;
    logic [7:0]            drop_left;
    logic [7:0]            drop_nx;
    logic [7:0]            tag;
    logic                  is_final;
    logic                  take_hdr;
    logic                  beat_hs;
    logic                  drop_hs;
    logic                  rvalid;
    logic                  rlast;
    logic [1:0]            rresp;
    logic [DATA_WIDTH-1:0] rdata;

    assign hdr      = cpl_hdr_t'(hdr_rdata);
    assign info     = decode_cpl_hdr(hdr);
    assign take_hdr = (state == IDLE) && !hdr_empty;
    assign beat_hs  = rvalid && r_if.rready;
    assign drop_hs  = (state == ERR) && (drop_left != '0) && !pld_empty;
    assign hdr_rden = take_hdr;
    assign pld_rden = ((state == DATA) && beat_hs) || drop_hs;

    assign r_if.rvalid = rvalid;
    assign r_if.rdata  = rdata;
    assign r_if.rresp  = rresp;
    assign r_if.rlast  = rlast;
    assign r_if.rid    = ID_WIDTH'(tag);

    // R channel: FIFO data passes straight through in DATA; ERR emits zero SLVERR beats
    always_comb begin
        rvalid = (state == DATA) ? !pld_empty : (state == ERR) && (beats_left != '0);
        rdata  = (state == DATA) ? pld_rdata : '0;
        rresp  = (state == ERR) ? RESP_SLVERR : RESP_OKAY;
        rlast  = (state == DATA) ? (beats_left == 8'd1) && is_final :
                 (state == ERR) && (beats_left == 8'd1);
    end

    // next state and beat/drain counters; ERR waits for both beats and payload drain
    always_comb begin
        state_nx = state;
        beats_nx = beats_left - 8'(beat_hs);
        drop_nx  = drop_left - 8'(drop_hs);
        case (state)
            IDLE: begin
                beats_nx = info.beats;
                drop_nx  = info.drop;
                state_nx = !take_hdr ? IDLE :
                           (info.kind == HDR_DATA) ? DATA :
                           (info.kind == HDR_ERR) ? ERR : IDLE;
            end
            DATA:    state_nx = (beats_nx == '0) ? IDLE : DATA;
            ERR:     state_nx = (beats_nx == '0 && drop_nx == '0) ? IDLE : ERR;
            default: state_nx = IDLE;
        endcase
    end

    // state, counters, per-completion context and the malformed pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beats_left    <= '0;
            drop_left     <= '0;
            tag           <= '0;
            is_final      <= 1'b0;
            err_malformed <= 1'b0;
        end else begin
            state         <= state_nx;
            beats_left    <= beats_nx;
            drop_left     <= drop_nx;
            err_malformed <= take_hdr && (info.kind == HDR_BAD);
            if (take_hdr) begin
                tag      <= hdr.tag;
                is_final <= info.is_final;
            end
        end
    end

endmodule

// File: tb/tb_cpld_r_maker.sv
// tb_cpld_r_maker: directed and randomized completion streams against a queue model
module tb_cpld_r_maker;

    typedef struct packed {
        logic [255:0] data;
        logic [1:0]   resp;
        logic         last;
        logic [7:0]   id;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         hdr_empty = 1'b1;
    logic [127:0] hdr_rdata = '0;
    logic         hdr_rden;
    logic         pld_empty = 1'b1;
    logic [255:0] pld_rdata = '0;
    logic         pld_rden;
    logic         err_malformed;

    AXI4_R_IF #(.DATA_WIDTH(256), .ID_WIDTH(8)) r_bus();

    cpld_r_maker #(.DATA_WIDTH(256), .ID_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .hdr_empty(hdr_empty),
        .hdr_rdata(hdr_rdata),
        .hdr_rden(hdr_rden),
        .pld_empty(pld_empty),
        .pld_rdata(pld_rdata),
        .pld_rden(pld_rden),
        .r_if(r_bus),
        .err_malformed(err_malformed)
    );

    always #5 clk = ~clk;

    logic [127:0] hdr_q[$];
    logic [255:0] pld_q[$];
    beat_t        obs_q[$];
    beat_t        exp_q[$];
    int asserts = 0;
    int fails = 0;
    int pld_pops, exp_pops, mal_cnt, exp_mal, hold_viol, rd_viol, overlap_viol;
    int rready_pct = 100;
    int hdr_gap = 0;
    int pld_gap = 0;
    int rready_block = 0;
    beat_t prev;
    logic  prev_hold;

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] mk_hdr(input logic [2:0] fmt, input logic [4:0] typ,
                                            input int len, input int status, input int bc, input int tag);
        logic [127:0] h;
        h = {$urandom, $urandom, $urandom, $urandom};
        h[31:29] = fmt;
        h[28:24] = typ;
        h[9:0]   = len[9:0];
        h[47:45] = status[2:0];
        h[43:32] = bc[11:0];
        h[79:72] = tag[7:0];
        return h;
    endfunction

    // Reference: a completion expands into payload words and expected R beats
    task automatic add_cpl(input logic [2:0] fmt, input logic [4:0] typ,
                           input int len, input int status, input int bc, input int tag);
        int len_dw = (len == 0) ? 1024 : len;
        int bytes = (bc == 0) ? 4096 : bc;
        int nd = (len_dw + 7) / 8;
        int ne = (bc == 0) ? 1 : (bc + 31) / 32;
        logic cpld = (fmt == 3'b010) && (typ == 5'b01010);
        logic cpl = (fmt == 3'b000) && (typ == 5'b01010);
        logic [255:0] w;
        hdr_q.push_back(mk_hdr(fmt, typ, len, status, bc, tag));
        if (!cpld && !cpl) begin
            exp_mal++;
            return;
        end
        if (cpld) begin
            for (int i = 0; i < nd; i++) begin
                w = rnd256();
                pld_q.push_back(w);
                exp_pops++;
                if (status == 0) exp_q.push_back({w, 2'b00, 1'((i == nd - 1) && (bytes <= len_dw * 4)), tag[7:0]});
            end
        end
        if (cpl || status != 0)
            for (int i = 0; i < ne; i++) exp_q.push_back({256'd0, 2'b10, 1'(i == ne - 1), tag[7:0]});
    endtask

    task automatic clear_model();
        obs_q.delete();
        exp_q.delete();
        pld_pops = 0; exp_pops = 0; mal_cnt = 0; exp_mal = 0;
        hold_viol = 0; rd_viol = 0; overlap_viol = 0;
        prev_hold = 1'b0;
    endtask

    // One clock: drive FIFO flags/data and rready, then record what the DUT does
    task automatic step();
        beat_t b;
        @(negedge clk);
        hdr_empty = (hdr_q.size() == 0) || ($urandom_range(99) < hdr_gap);
        hdr_rdata = (hdr_q.size() != 0) ? hdr_q[0] : {$urandom, $urandom, $urandom, $urandom};
        pld_empty = (pld_q.size() == 0) || ($urandom_range(99) < pld_gap);
        pld_rdata = (pld_q.size() != 0) ? pld_q[0] : rnd256();
        r_bus.rready = (rready_block > 0) ? 1'b0 : ($urandom_range(99) < rready_pct);
        if (rready_block > 0) rready_block--;
        #1;
        b.data = r_bus.rdata; b.resp = r_bus.rresp; b.last = r_bus.rlast; b.id = r_bus.rid;
        if (prev_hold && !(r_bus.rvalid && b == prev)) hold_viol++;
        prev_hold = r_bus.rvalid && !r_bus.rready && (b.resp == 2'b10);
        prev = b;
        if (r_bus.rvalid && r_bus.rready) obs_q.push_back(b);
        if (r_bus.rvalid && hdr_rden) overlap_viol++;
        if (hdr_rden) begin
            if (hdr_empty) rd_viol++;
            else void'(hdr_q.pop_front());
        end
        if (pld_rden) begin
            pld_pops++;
            if (pld_empty) rd_viol++;
            else void'(pld_q.pop_front());
        end
        if (err_malformed) mal_cnt++;
    endtask

    task automatic run(input int max_cyc);
        int n = 0;
        while ((hdr_q.size() != 0 || pld_q.size() != 0 || obs_q.size() < exp_q.size()) && n < max_cyc) begin
            step();
            n++;
        end
        asserts++;
        if (n >= max_cyc) begin
            fails++;
            $display("FAIL run_timeout: %0d cycles used, limit %0d (hdr=%0d pld=%0d beats %0d/%0d)",
                     n, max_cyc, hdr_q.size(), pld_q.size(), obs_q.size(), exp_q.size());
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        asserts++; if (r_bus.rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b exp 0", r_bus.rvalid); end
        asserts++; if (r_bus.rlast !== 1'b0) begin fails++; $display("FAIL reset_rlast: got %b exp 0", r_bus.rlast); end
        asserts++; if (r_bus.rresp !== 2'b00) begin fails++; $display("FAIL reset_rresp: got %b exp 00", r_bus.rresp); end
        asserts++; if (r_bus.rid !== 8'h00) begin fails++; $display("FAIL reset_rid: got %h exp 00", r_bus.rid); end
        asserts++; if (r_bus.rdata !== 256'd0) begin fails++; $display("FAIL reset_rdata: got %h exp 0", r_bus.rdata); end
        asserts++; if (hdr_rden !== 1'b0) begin fails++; $display("FAIL reset_hdr_rden: got %b exp 0", hdr_rden); end
        asserts++; if (pld_rden !== 1'b0) begin fails++; $display("FAIL reset_pld_rden: got %b exp 0", pld_rden); end
        asserts++; if (err_malformed !== 1'b0) begin fails++; $display("FAIL reset_err_malformed: got %b exp 0", err_malformed); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_model();
        add_cpl(3'b010, 5'b01010, 16, 0, 64, 8'h05);
        run(200);
        asserts++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL single_count: got %0d beats exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL single_beat%0d: got resp=%b last=%b id=%h data=%h exp resp=%b last=%b id=%h data=%h", i, obs_q[i].resp, obs_q[i].last, obs_q[i].id, obs_q[i].data, exp_q[i].resp, exp_q[i].last, exp_q[i].id, exp_q[i].data); end
        end
        asserts++; if (pld_pops != exp_pops) begin fails++; $display("FAIL single_pops: got %0d exp %0d", pld_pops, exp_pops); end
        asserts++; if (hold_viol + rd_viol + overlap_viol != 0) begin fails++; $display("FAIL single_protocol: hold=%0d rd=%0d overlap=%0d exp 0", hold_viol, rd_viol, overlap_viol); end
    endtask

    task automatic test_split();
        clear_model();
        add_cpl(3'b010, 5'b01010, 16, 0, 128, 8'h07);
        add_cpl(3'b010, 5'b01010, 16, 0, 64, 8'h07);
        run(200);
        asserts++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL split_count: got %0d beats exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL split_beat%0d: got resp=%b last=%b id=%h data=%h exp resp=%b last=%b id=%h data=%h", i, obs_q[i].resp, obs_q[i].last, obs_q[i].id, obs_q[i].data, exp_q[i].resp, exp_q[i].last, exp_q[i].id, exp_q[i].data); end
        end
        asserts++; if (pld_pops != exp_pops) begin fails++; $display("FAIL split_pops: got %0d exp %0d", pld_pops, exp_pops); end
        asserts++; if (hold_viol + rd_viol + overlap_viol != 0) begin fails++; $display("FAIL split_protocol: hold=%0d rd=%0d overlap=%0d exp 0", hold_viol, rd_viol, overlap_viol); end
    endtask

    task automatic test_err_cpl();
        clear_model();
        rready_pct = 50;
        add_cpl(3'b000, 5'b01010, 0, 1, 96, 8'h3c);
        run(200);
        rready_pct = 100;
        asserts++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL err_count: got %0d beats exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL err_beat%0d: got resp=%b last=%b id=%h data=%h exp resp=%b last=%b id=%h data=%h", i, obs_q[i].resp, obs_q[i].last, obs_q[i].id, obs_q[i].data, exp_q[i].resp, exp_q[i].last, exp_q[i].id, exp_q[i].data); end
        end
        asserts++; if (pld_pops != 0) begin fails++; $display("FAIL err_pops: got %0d exp 0", pld_pops); end
        asserts++; if (hold_viol + rd_viol + overlap_viol != 0) begin fails++; $display("FAIL err_protocol: hold=%0d rd=%0d overlap=%0d exp 0", hold_viol, rd_viol, overlap_viol); end
    endtask

    task automatic test_malformed();
        clear_model();
        add_cpl(3'b011, 5'b00000, 4, 0, 16, 8'h11);
        add_cpl(3'b010, 5'b01010, 8, 0, 32, 8'h09);
        run(200);
        asserts++; if (mal_cnt != exp_mal) begin fails++; $display("FAIL malformed_pulses: got %0d cycles exp %0d", mal_cnt, exp_mal); end
        asserts++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL malformed_count: got %0d beats exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL malformed_beat%0d: got resp=%b last=%b id=%h exp resp=%b last=%b id=%h", i, obs_q[i].resp, obs_q[i].last, obs_q[i].id, exp_q[i].resp, exp_q[i].last, exp_q[i].id); end
        end
        asserts++; if (rd_viol + overlap_viol != 0) begin fails++; $display("FAIL malformed_protocol: rd=%0d overlap=%0d exp 0", rd_viol, overlap_viol); end
    endtask

    task automatic test_back_to_back_stall();
        clear_model();
        rready_block = 5;
        pld_gap = 50;
        add_cpl(3'b010, 5'b01010, 8, 0, 32, 8'h21);
        run(300);
        pld_gap = 0;
        asserts++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL stall_count: got %0d beats exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL stall_beat%0d: got last=%b id=%h data=%h exp last=%b id=%h data=%h", i, obs_q[i].last, obs_q[i].id, obs_q[i].data, exp_q[i].last, exp_q[i].id, exp_q[i].data); end
        end
        asserts++; if (pld_pops != 1) begin fails++; $display("FAIL stall_pops: got %0d exp 1", pld_pops); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_model();
        add_cpl(3'b010, 5'b01010, 32, 0, 128, 8'h03);
        while (obs_q.size() < 2 && n < 200) begin step(); n++; end
        asserts++; if (obs_q.size() != 2) begin fails++; $display("FAIL midrst_prefix: got %0d beats exp 2", obs_q.size()); end
        @(negedge clk);
        rst = 1'b1; r_bus.rready = 1'b0; hdr_empty = 1'b1; pld_empty = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hdr_q.delete();
        pld_q.delete();
        clear_model();
        #1;
        asserts++; if (r_bus.rvalid !== 1'b0) begin fails++; $display("FAIL midrst_rvalid: got %b exp 0", r_bus.rvalid); end
        add_cpl(3'b010, 5'b01010, 8, 0, 32, 8'h44);
        hdr_empty = 1'b0;
        hdr_rdata = hdr_q[0];
        #1;
        asserts++; if (hdr_rden !== 1'b1) begin fails++; $display("FAIL midrst_idle: hdr_rden got %b exp 1", hdr_rden); end
        hdr_empty = 1'b1;
        run(200);
        asserts++; if (obs_q.size() != 1) begin fails++; $display("FAIL midrst_count: got %0d beats exp 1", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL midrst_beat%0d: got last=%b id=%h data=%h exp last=%b id=%h data=%h", i, obs_q[i].last, obs_q[i].id, obs_q[i].data, exp_q[i].last, exp_q[i].id, exp_q[i].data); end
        end
    endtask

    task automatic test_random();
        int kind, len, bc, st;
        clear_model();
        rready_pct = 60; hdr_gap = 30; pld_gap = 25;
        for (int c = 0; c < 30; c++) begin
            kind = $urandom_range(9);
            len = (kind == 9) ? 0 : $urandom_range(1, 40);
            bc = $urandom_range(1) ? ((len == 0 ? 4096 : len * 4) - $urandom_range(0, 3)) % 4096 : $urandom_range(4095);
            st = $urandom_range(1, 7);
            if (kind <= 5 || kind == 9) add_cpl(3'b010, 5'b01010, len, 0, bc, $urandom_range(255));
            else if (kind == 6) add_cpl(3'b000, 5'b01010, 0, $urandom_range(1) ? st : 0, $urandom_range(300), $urandom_range(255));
            else if (kind == 7) add_cpl(3'b010, 5'b01010, len, st, bc, $urandom_range(255));
            else add_cpl($urandom_range(1) ? 3'b011 : 3'b010, $urandom_range(1) ? 5'b00000 : 5'b01011, len, 0, bc, $urandom_range(255));
        end
        run(20000);
        rready_pct = 100; hdr_gap = 0; pld_gap = 0;
        asserts++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL random_count: got %0d beats exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL random_beat%0d: got resp=%b last=%b id=%h data=%h exp resp=%b last=%b id=%h data=%h", i, obs_q[i].resp, obs_q[i].last, obs_q[i].id, obs_q[i].data, exp_q[i].resp, exp_q[i].last, exp_q[i].id, exp_q[i].data); end
        end
        asserts++; if (pld_pops != exp_pops) begin fails++; $display("FAIL random_pops: got %0d exp %0d", pld_pops, exp_pops); end
        asserts++; if (mal_cnt != exp_mal) begin fails++; $display("FAIL random_malformed: got %0d exp %0d", mal_cnt, exp_mal); end
        asserts++; if (hold_viol + rd_viol + overlap_viol != 0) begin fails++; $display("FAIL random_protocol: hold=%0d rd=%0d overlap=%0d exp 0", hold_viol, rd_viol, overlap_viol); end
    endtask

    initial begin
        r_bus.rready = 1'b0;
        test_reset();
        test_single();
        test_split();
        test_err_cpl();
        test_malformed();
        test_back_to_back_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
